// File: rtl/maj_vote_seq.sv
// Bit-serial majority-vote sequencer: steps three redundant words LSB first through an
// external 3-input voter. Optional fault counters are enabled by MAJ_VOTE_ERRCNT_EN.
`timescale 1ns/1ps

module maj_vote_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    output logic [2:0]       vote_i,
    input  logic             vote_o,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic [2:0]       disagree,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VOTE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     c_reg;
    logic [W-1:0]     res_sh_reg;
    logic [2:0]       acc_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [W-1:0]     result_reg;
    logic [2:0]       disagree_reg;

    logic [2:0]       bit_now;
    logic [2:0]       mis_now;
    logic [W-1:0]     res_next;

    // Current bit of each captured channel, its mismatch against the voter,
    // and the result word with the current voted bit merged in.
    always_comb begin
        bit_now           = {c_reg[idx_reg], b_reg[idx_reg], a_reg[idx_reg]};
        mis_now           = bit_now ^ {3{vote_o}};
        res_next          = res_sh_reg;
        res_next[idx_reg] = vote_o;
    end

    assign vote_i   = (state_reg == VOTE) ? bit_now : 3'b000;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign disagree = disagree_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            c_reg        <= '0;
            res_sh_reg   <= '0;
            acc_reg      <= 3'b000;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            disagree_reg <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        c_reg     <= c;
                        idx_reg   <= '0;
                        acc_reg   <= 3'b000;
                        busy_reg  <= 1'b1;
                        state_reg <= VOTE;
                    end
                end
                VOTE: begin
                    res_sh_reg <= res_next;
                    acc_reg    <= acc_reg | mis_now;
                    // Last bit: publish directly from the merged values so the
                    // outputs are valid in the same cycle done rises.
                    if (idx_reg == IDX_LAST) begin
                        result_reg   <= res_next;
                        disagree_reg <= acc_reg | mis_now;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef MAJ_VOTE_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // One saturating counter per channel; clear has priority over increment.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (err_clr) begin
                cnt_reg <= '0;
            end else if (done_reg && disagree_reg[gi] && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign err_cnt_a = g_cnt[0].cnt_reg;
    assign err_cnt_b = g_cnt[1].cnt_reg;
    assign err_cnt_c = g_cnt[2].cnt_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt_a      = '0;
    assign err_cnt_b      = '0;
    assign err_cnt_c      = '0;
`endif

endmodule

// File: tb/tb_maj_vote_seq.sv
// Self-checking bench for maj_vote_seq: word-level majority model feeding a scoreboard,
// plus per-scenario tasks for reset, vote pattern, handshake, abort and fault counters.
`timescale 1ns/1ps

module tb_maj_vote_seq;

    localparam int W     = 8;
    localparam int CNT_W = 8;
`ifdef MAJ_VOTE_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a, b, c;
    logic [2:0]       vote_i;
    logic             vote_o;
    logic             busy, done;
    logic [W-1:0]     result;
    logic [2:0]       disagree;
    logic             err_clr;
    logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

    maj_vote_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .c(c),
        .vote_i(vote_i), .vote_o(vote_o),
        .busy(busy), .done(done),
        .result(result), .disagree(disagree),
        .err_clr(err_clr),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
    );

    always #5 clk = ~clk;

    // External shared voter
    assign vote_o = (vote_i[0] & vote_i[1]) | (vote_i[0] & vote_i[2]) | (vote_i[1] & vote_i[2]);

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   dis;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   done_cycs[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   rem      = 0;
    int   done_cnt = 0;

    // Reference model: tracks acceptance and pushes the expected word on each accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= 0;
            sb_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (rem == 0 && start) begin
                exp_t e;
                e.res = (a & b) | (a & c) | (b & c);
                e.dis = {|(c ^ e.res), |(b ^ e.res), |(a ^ e.res)};
                e.cyc = cyc + 1 + W;
                sb_q.push_back(e);
                rem <= W + 1;
            end else if (rem > 0) begin
                rem <= rem - 1;
            end
        end
    end

    // Output monitor: busy tracking and scoreboard pop on done
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy !== (rem != 0)) begin
                errors++;
                $display("FAIL busy: got %b expected %b at cycle %0d", busy, (rem != 0), cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cycs.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done high with empty scoreboard at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checks += 3;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", result, e.res);
                    end
                    if (disagree !== e.dis) begin
                        errors++;
                        $display("FAIL disagree: got %b expected %b", disagree, e.dis);
                    end
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL done_timing: got cycle %0d expected %0d", cyc, e.cyc);
                    end
                end
                $display("word done: result=%h disagree=%b cycle=%0d", result, disagree, cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] wa, input logic [W-1:0] wb, input logic [W-1:0] wc);
        @(negedge clk);
        a = wa; b = wb; c = wc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while ((rem != 0 || sb_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ok = (n < 60);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; err_clr = 1'b0;
        a = 8'hFF; b = 8'hFF; c = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, result, disagree, vote_i, err_cnt_a, err_cnt_b, err_cnt_c} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got busy=%b done=%b result=%h dis=%b vote_i=%b cnt=%h/%h/%h expected all 0",
                         busy, done, result, disagree, vote_i, err_cnt_a, err_cnt_b, err_cnt_c);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        $display("reset: outputs held at zero");
    endtask

    task automatic test_unanimous();
        logic [W-1:0] pat = 8'hA5;
        bit ok;
        @(negedge clk);
        a = pat; b = pat; c = pat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (vote_i !== {3{pat[i]}}) begin
                errors++;
                $display("FAIL vote_i_bit%0d: got %b expected %b", i, vote_i, {3{pat[i]}});
            end
            @(negedge clk);
        end
        checks += 2;
        if (vote_i !== 3'b000) begin
            errors++;
            $display("FAIL vote_i_done: got %b expected 000", vote_i);
        end
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 1", done);
        end
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL unanimous_timeout: got timeout expected idle"); end
        if (result !== 8'hA5) begin errors++; $display("FAIL unanimous_result: got %h expected a5", result); end
        if (disagree !== 3'b000) begin errors++; $display("FAIL unanimous_dis: got %b expected 000", disagree); end
    endtask

    task automatic test_split();
        bit ok;
        send(8'hFF, 8'h0F, 8'hF0);
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL split1_timeout: got timeout expected idle"); end
        if (result !== 8'hFF) begin errors++; $display("FAIL split1_result: got %h expected ff", result); end
        if (disagree !== 3'b110) begin errors++; $display("FAIL split1_dis: got %b expected 110", disagree); end
        send(8'h00, 8'h3C, 8'h3C);
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL split2_timeout: got timeout expected idle"); end
        if (result !== 8'h3C) begin errors++; $display("FAIL split2_result: got %h expected 3c", result); end
        if (disagree !== 3'b001) begin errors++; $display("FAIL split2_dis: got %b expected 001", disagree); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        bit ok;
        done_cycs.delete();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: got timeout expected idle"); end
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d words expected 2", done_cnt - d0);
        end
        if (done_cycs.size() != 2 || done_cycs[1] - done_cycs[0] != W + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d done pulses expected 2 spaced %0d cycles", done_cycs.size(), W + 2);
        end
    endtask

    task automatic test_abort();
        int d0;
        bit ok;
        send(8'h12, 8'h34, 8'h56);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, disagree, vote_i, err_cnt_a, err_cnt_b, err_cnt_c} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h dis=%b vote_i=%b expected all 0",
                     busy, done, result, disagree, vote_i);
        end
        d0 = done_cnt;
        repeat (W + 4) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt - d0);
        end
        send(8'h11, 8'h11, 8'h00);
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL abort_timeout: got timeout expected idle"); end
        if (result !== 8'h11) begin errors++; $display("FAIL abort_result: got %h expected 11", result); end
        if (disagree !== 3'b100) begin errors++; $display("FAIL abort_dis: got %b expected 100", disagree); end
    endtask

    task automatic test_counters();
        bit ok;
        int exp_a;
        int n;
        logic [W-1:0] wb;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++;
        if ({err_cnt_a, err_cnt_b, err_cnt_c} !== '0) begin
            errors++;
            $display("FAIL cnt_clear: got %h/%h/%h expected 0/0/0", err_cnt_a, err_cnt_b, err_cnt_c);
        end
        for (int i = 1; i <= 300; i++) begin
            wb = W'($urandom);
            send(wb ^ (W'(1) << (i % W)), wb, wb);
            wait_idle(ok);
            exp_a = CNT_EN ? ((i > 255) ? 255 : i) : 0;
            if (!ok || i == 100 || i == 255 || i == 300) begin
                checks += 2;
                if (!ok) begin errors++; $display("FAIL cnt_timeout: got timeout at word %0d expected idle", i); end
                if (err_cnt_a !== CNT_W'(exp_a)) begin
                    errors++;
                    $display("FAIL cnt_a_word%0d: got %0d expected %0d", i, err_cnt_a, exp_a);
                end
            end
        end
        checks++;
        if (err_cnt_b !== '0 || err_cnt_c !== '0) begin
            errors++;
            $display("FAIL cnt_bc: got %0d/%0d expected 0/0", err_cnt_b, err_cnt_c);
        end
        $display("counters: a=%0d b=%0d c=%0d after 300 words", err_cnt_a, err_cnt_b, err_cnt_c);
        // Clear, one counted word, then clear coinciding with a done that would increment.
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        send(8'h01, 8'h00, 8'h00);
        wait_idle(ok);
        checks++;
        if (err_cnt_a !== CNT_W'(CNT_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL cnt_one: got %0d expected %0d", err_cnt_a, CNT_EN ? 1 : 0);
        end
        send(8'h80, 8'h00, 8'h00);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks += 2;
        if (n >= 30) begin errors++; $display("FAIL clr_wait: got timeout expected done"); end
        if ({err_cnt_a, err_cnt_b, err_cnt_c} !== '0) begin
            errors++;
            $display("FAIL clr_wins: got %0d/%0d/%0d expected 0/0/0", err_cnt_a, err_cnt_b, err_cnt_c);
        end
        wait_idle(ok);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; err_clr = 1'b0;
        a = '0; b = '0; c = '0;
        test_reset();
        test_unanimous();
        test_split();
        test_back_to_back();
        test_abort();
        test_counters();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
